// File: rtl/synch_master_if.sv
// Handshake/result bundle between the ring transmitter logic and the synch master.
interface synch_master_if;
  logic       Start;
  logic       TxBusy;
  logic       RxFrameValid;
  logic [7:0] LastSlaveIDPlus1;
  logic [7:0] AveSlaveDelay;
  logic       DelayValid;
  logic       MeasBusy;
  logic       Timeout;
  logic       SynchSignal;

  modport master (
    output Start, TxBusy, RxFrameValid, LastSlaveIDPlus1,
    input  AveSlaveDelay, DelayValid, MeasBusy, Timeout, SynchSignal
  );

  modport slave (
    input  Start, TxBusy, RxFrameValid, LastSlaveIDPlus1,
    output AveSlaveDelay, DelayValid, MeasBusy, Timeout, SynchSignal
  );
endinterface

// File: rtl/synch_master.sv
// Measures ring round-trip delay, divides by hop count (N+1) to get the per-hop
// delay, and emits a synch strobe delayed to line up with the last slave.
module synch_master #(
  parameter int              CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic         Clk_100MHz,
  input  logic         Reset,
  synch_master_if.slave bus
);
  localparam int BW = $clog2(CNT_W);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DIVIDE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] quo_q, quo_d;
  logic [7:0]       rem_q, rem_d;
  logic [8:0]       div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [7:0]       ave_q, ave_d;
  logic             dv_q, dv_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;
  logic [31:0]      sync_q, sync_d;

  // Restoring divider datapath: dividend shifts out of quo_q MSB-first while
  // quotient bits shift in at the LSB. Remainder never exceeds 255.
  logic [8:0]       rem_sh;
  logic             ge;
  logic [7:0]       rem_nx;
  logic [CNT_W-1:0] q_shift;
  logic [31:0]      thr;

  assign rem_sh  = {rem_q, quo_q[CNT_W-1]};
  assign ge      = (rem_sh >= div_q);
  assign rem_nx  = ge ? 8'(rem_sh - div_q) : rem_sh[7:0];
  assign q_shift = {quo_q[CNT_W-2:0], ge};
  assign thr     = {24'd0, bus.LastSlaveIDPlus1} * {24'd0, ave_q} + 32'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ave_d   = ave_q;
    dv_d    = dv_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.Start) state_d = ARM;
      ARM: begin
        if (!bus.TxBusy) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A frame arriving on the timeout cycle still counts as a measurement.
        if (bus.RxFrameValid) begin
          quo_d   = cnt_q;
          rem_d   = '0;
          bit_d   = '0;
          div_d   = {1'b0, bus.LastSlaveIDPlus1} + 9'd1;
          state_d = DIVIDE;
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        quo_d = q_shift;
        rem_d = rem_nx;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(CNT_W - 1)) begin
          ave_d   = (q_shift[CNT_W-1:8] != '0) ? 8'hFF : q_shift[7:0];
          dv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    sync_d = sync_q;
    if (bus.TxBusy || !dv_q)  sync_d = '0;
    else if (sync_q != '1)    sync_d = sync_q + 32'd1;
  end

  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ave_q   <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ave_q   <= ave_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.AveSlaveDelay = ave_q;
  assign bus.DelayValid    = dv_q;
  assign bus.MeasBusy      = busy_q;
  assign bus.Timeout       = to_q;
  assign bus.SynchSignal   = dv_q & ~bus.TxBusy & (sync_q >= thr);
endmodule

// File: tb/tb_synch_master.sv
// Directed bench: two instances, default timeout (m) and TIMEOUT_CYCLES=100 (t).
module tb_synch_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_m = 1'b0, start_t = 1'b0;
  logic       txbusy = 1'b0, rxv = 1'b0;
  logic [7:0] n_in = 8'd0;
  int         n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  synch_master_if m_if ();
  synch_master_if t_if ();

  assign m_if.Start = start_m;
  assign t_if.Start = start_t;
  assign m_if.TxBusy = txbusy;
  assign t_if.TxBusy = txbusy;
  assign m_if.RxFrameValid = rxv;
  assign t_if.RxFrameValid = rxv;
  assign m_if.LastSlaveIDPlus1 = n_in;
  assign t_if.LastSlaveIDPlus1 = n_in;

  synch_master u_m (.Clk_100MHz(clk), .Reset(rst), .bus(m_if));
  synch_master #(.TIMEOUT_CYCLES(24'd100)) u_t (.Clk_100MHz(clk), .Reset(rst), .bus(t_if));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_ave(bit s);
    return 32'(s ? t_if.AveSlaveDelay : m_if.AveSlaveDelay);
  endfunction
  function automatic logic [31:0] o_dv(bit s);
    return 32'(s ? t_if.DelayValid : m_if.DelayValid);
  endfunction
  function automatic logic [31:0] o_busy(bit s);
    return 32'(s ? t_if.MeasBusy : m_if.MeasBusy);
  endfunction
  function automatic logic [31:0] o_to(bit s);
    return 32'(s ? t_if.Timeout : m_if.Timeout);
  endfunction

  task automatic set_start(input bit s, input logic v);
    if (s) start_t = v; else start_m = v;
  endtask

  // Full measurement: frame returns on MEASURE count rt; result loads 24 edges later.
  task automatic run(input bit s, input logic [7:0] n, input int rt, input int exp_ave,
                     input int old_ave, input int old_dv, input bit poke);
    n_in = n;
    txbusy = 1'b0;
    set_start(s, 1'b1);
    tick;
    set_start(s, 1'b0);
    chk("busy_arm", o_busy(s), 1);
    tick;
    for (int i = 0; i < rt; i++) begin
      if (poke && i == 5) set_start(s, 1'b1);
      tick;
      set_start(s, 1'b0);
    end
    rxv = 1'b1;
    tick;
    rxv = 1'b0;
    chk("no_timeout", o_to(s), 0);
    for (int i = 1; i < 24; i++) begin
      if (poke && i == 5) set_start(s, 1'b1);
      if (poke && i == 3) n_in = 8'd0;
      tick;
      set_start(s, 1'b0);
    end
    chk("hold_ave", o_ave(s), old_ave);
    chk("hold_dv", o_dv(s), old_dv);
    chk("busy_div", o_busy(s), 1);
    tick;
    n_in = n;
    chk("ave", o_ave(s), exp_ave);
    chk("dv", o_dv(s), 1);
    chk("busy_done", o_busy(s), 0);
    tick;
    chk("no_restart", o_busy(s), 0);
  endtask

  initial begin
    #12;
    chk("rst_ave", o_ave(0), 0);
    chk("rst_dv", o_dv(0), 0);
    chk("rst_busy", o_busy(0), 0);
    chk("rst_to", o_to(0), 0);
    chk("rst_ss", 32'(m_if.SynchSignal), 0);
    chk("rst_t_busy", o_busy(1), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // N=3, round trip 40 -> 40/4 = 10
    run(0, 8'd3, 40, 10, 0, 0, 0);

    // Synch strobe: threshold 3*10+1 = 31 idle cycles
    txbusy = 1'b1;
    tick;
    tick;
    chk("ss_busy", 32'(m_if.SynchSignal), 0);
    txbusy = 1'b0;
    repeat (30) tick;
    chk("ss_c30", 32'(m_if.SynchSignal), 0);
    tick;
    chk("ss_c31", 32'(m_if.SynchSignal), 1);
    repeat (5) tick;
    chk("ss_hold", 32'(m_if.SynchSignal), 1);
    txbusy = 1'b1;
    #1;
    chk("ss_drop", 32'(m_if.SynchSignal), 0);
    tick;

    // Start pokes during MEASURE/DIVIDE ignored; N change during DIVIDE ignored: 77/5 = 15
    run(0, 8'd4, 77, 15, 10, 1, 1);
    // N=0 divide by 1, saturate 1000 -> 255
    run(0, 8'd0, 1000, 255, 15, 1, 0);
    // N=255 -> 9-bit divisor 256: 5000/256 = 19
    run(0, 8'd255, 5000, 19, 255, 1, 0);
    // Frame on first MEASURE cycle -> 0
    run(0, 8'd2, 0, 0, 19, 1, 0);

    // Async reset on DIVIDE cycle 10
    n_in = 8'd3;
    txbusy = 1'b0;
    start_m = 1'b1;
    tick;
    start_m = 1'b0;
    tick;
    repeat (40) tick;
    rxv = 1'b1;
    tick;
    rxv = 1'b0;
    repeat (9) tick;
    chk("pre_rst_busy", o_busy(0), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ave", o_ave(0), 0);
    chk("arst_dv", o_dv(0), 0);
    chk("arst_busy", o_busy(0), 0);
    chk("arst_to", o_to(0), 0);
    chk("arst_ss", 32'(m_if.SynchSignal), 0);
    tick;
    rst = 1'b0;
    run(0, 8'd3, 40, 10, 0, 0, 0);

    // Timeout instance: prior result 50/2 = 25
    run(1, 8'd1, 50, 25, 0, 0, 0);
    n_in = 8'd1;
    start_t = 1'b1;
    tick;
    start_t = 1'b0;
    tick;
    repeat (100) tick;
    chk("to_pre", o_to(1), 0);
    chk("to_pre_busy", o_busy(1), 1);
    tick;
    chk("to_pulse", o_to(1), 1);
    chk("to_idle", o_busy(1), 0);
    chk("to_keep_ave", o_ave(1), 25);
    chk("to_keep_dv", o_dv(1), 1);
    tick;
    chk("to_single", o_to(1), 0);
    // Frame on the timeout cycle wins: RoundTrip=100, N=0
    run(1, 8'd0, 100, 100, 25, 1, 0);
    chk("to_none_after", o_to(1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
